// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer.
// Optional per-channel transfer counters are enabled with DEMUX_XFER_CNT_EN.
package demux_pkg;

    localparam int CH_NUM = 4;   // number of destination channels
    localparam int SEL_W  = 2;   // select width, covers CH_NUM codes
    localparam int CNT_W  = 16;  // per-channel transfer counter width

    typedef logic [SEL_W-1:0] chan_idx_t;

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel of the demultiplexer: a one-deep holding register with
// a valid flag. A load always wins over a drain, so a same-cycle drain+load
// replaces the word and keeps valid high (full throughput).
// When DEMUX_XFER_CNT_EN is defined, a wrapping counter of completed output
// transfers (valid & ready) is added.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 48
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
`ifdef DEMUX_XFER_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    // Holding register: reset, then load, then drain, otherwise hold.
    // The data register keeps its last value after a drain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

`ifdef DEMUX_XFER_CNT_EN
    // Count every word handed to the consumer; wraps naturally at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (valid && ready) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready on input and per-channel
// outputs. The top holds only accept/decode; storage lives in demux_chan_reg.
// in_ready is the only combinational output and never depends on in_valid
// or in_data. Optional transfer counters: define DEMUX_XFER_CNT_EN.
module demux1to4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 48
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [WIDTH-1:0]        in_data,
    input  chan_idx_t               in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CH_NUM*WIDTH-1:0] out_data,
    output logic [CH_NUM-1:0]       out_valid,
    input  logic [CH_NUM-1:0]       out_ready
`ifdef DEMUX_XFER_CNT_EN
    ,
    output logic [CH_NUM*CNT_W-1:0] xfer_cnt
`endif
);

    logic [CH_NUM-1:0] load;

    // Accept when the selected channel is empty or draining this cycle;
    // the state of other channels never unblocks the input.
    always_comb begin
        in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    end

    // One-hot load strobe toward the selected channel on a transfer.
    always_comb begin
        load = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            load[i] = in_valid & in_ready & (in_sel == chan_idx_t'(i));
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        demux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_chan (
            .CLK       (CLK),
            .RST       (RST),
            .load      (load[g]),
            .load_data (in_data),
            .ready     (out_ready[g]),
            .data      (out_data[g*WIDTH +: WIDTH]),
            .valid     (out_valid[g])
`ifdef DEMUX_XFER_CNT_EN
            ,
            .cnt       (xfer_cnt[g*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_demux1to4_reg.sv
// Self-checking bench for demux1to4_reg: directed scenarios plus a randomized
// stream, checked against a behavioural channel model and per-channel
// in-order scoreboards. Builds with or without DEMUX_XFER_CNT_EN.
module tb_demux1to4_reg;

    localparam int W  = 48;
    localparam int CH = 4;
    localparam int CW = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [W-1:0]    in_data;
    logic [1:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] out_data;
    logic [CH-1:0]   out_valid;
    logic [CH-1:0]   out_ready;
`ifdef DEMUX_XFER_CNT_EN
    logic [CH*CW-1:0] xfer_cnt;
`endif

    demux1to4_reg #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what each channel currently holds, plus counters.
    logic [W-1:0]  m_data [CH];
    logic [CH-1:0] m_valid;
    logic [CW-1:0] m_cnt  [CH];
    // Scoreboard: words accepted for each channel, not yet consumed.
    logic [W-1:0]  sb_q   [CH][$];

    task automatic check(input string tag, input logic [CH*W-1:0] got, input logic [CH*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CH*W-1:0] m_data_vec();
        logic [CH*W-1:0] v;
        for (int i = 0; i < CH; i++) v[i*W +: W] = m_data[i];
        return v;
    endfunction

    function automatic logic model_ready();
        return !m_valid[in_sel] || out_ready[in_sel];
    endfunction

    // Check outputs against the model, then advance one clock and update the
    // model with what the just-sampled inputs should have caused.
    task automatic tick();
        logic          rdy;
        logic          acc;
        logic [CH-1:0] drain;
        #1;
        rdy = model_ready();
        check("in_ready", {191'b0, in_ready}, {191'b0, rdy});
        check("out_valid", {188'b0, out_valid}, {188'b0, m_valid});
        check("out_data", out_data, m_data_vec());
`ifdef DEMUX_XFER_CNT_EN
        begin
            logic [CH*CW-1:0] ec;
            for (int i = 0; i < CH; i++) ec[i*CW +: CW] = m_cnt[i];
            check("xfer_cnt", {128'b0, xfer_cnt}, {128'b0, ec});
        end
`endif
        acc   = in_valid && rdy;
        drain = m_valid & out_ready;
        if (!RST) begin
            for (int i = 0; i < CH; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sb_q[i].size() == 0) begin
                        check("sb_unexpected", {191'b0, 1'b1}, '0);
                    end else begin
                        check("sb_order", {144'b0, out_data[i*W +: W]}, {144'b0, sb_q[i].pop_front()});
                    end
                end
            end
            if (acc) sb_q[in_sel].push_back(in_data);
        end
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < CH; i++) begin
                m_data[i] = '0;
                m_cnt[i]  = '0;
                sb_q[i].delete();
            end
            m_valid = '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (drain[i]) begin
                    m_cnt[i]++;
                    m_valid[i] = 1'b0;
                end
            end
            if (acc) begin
                m_data[in_sel]  = in_data;
                m_valid[in_sel] = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        int sent;
        int budget;
        logic [W-1:0] a_word;
        logic [W-1:0] b_word;
        logic [W-1:0] c_word;
        logic [W-1:0] d_word;

        RST = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
        for (int i = 0; i < CH; i++) begin
            m_data[i] = '0; m_cnt[i] = '0;
        end
        m_valid = '0;
        @(posedge CLK); #1;

        // Reset held two cycles with random inputs.
        for (int k = 0; k < 2; k++) begin
            in_data   = {$urandom, $urandom};
            in_sel    = 2'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 4'($urandom);
            #1;
            check("rst_in_ready", {191'b0, in_ready}, {191'b0, 1'b1});
            tick();
        end
        RST = 1'b0; in_valid = 1'b0; out_ready = '1;
        #1;
        check("post_rst_valid", {188'b0, out_valid}, '0);
        check("post_rst_data", out_data, '0);
        check("post_rst_ready", {191'b0, in_ready}, {191'b0, 1'b1});

        // Single routing to channel 2.
        in_data = 48'h0000_1234_5678; in_sel = 2'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("route_valid", {188'b0, out_valid}, {188'b0, 4'b0100});
        check("route_data", {144'b0, out_data[2*W +: W]}, {144'b0, 48'h0000_1234_5678});
        tick();
        check("route_clear", {188'b0, out_valid}, '0);

        // Backpressure on channel 1.
        a_word = 48'hAAAA_0000_0001; b_word = 48'hBBBB_0000_0002;
        out_ready = 4'b1101;
        in_data = a_word; in_sel = 2'd1; in_valid = 1'b1;
        tick();
        in_data = b_word;
        #1;
        check("bp_stall", {191'b0, in_ready}, '0);
        tick();
        check("bp_hold", {144'b0, out_data[1*W +: W]}, {144'b0, a_word});
        out_ready = 4'b1111;
        #1;
        check("bp_release", {191'b0, in_ready}, {191'b0, 1'b1});
        tick();
        in_valid = 1'b0;
        check("bp_swap_valid", {191'b0, out_valid[1]}, {191'b0, 1'b1});
        check("bp_swap_data", {144'b0, out_data[1*W +: W]}, {144'b0, b_word});
        tick();

        // Independence: channel 0 stalled full, channel 3 still accepts.
        c_word = 48'hCCCC_3333_0003; d_word = 48'hDDDD_0000_0004;
        out_ready = 4'b1110;
        in_data = d_word; in_sel = 2'd0; in_valid = 1'b1;
        tick();
        in_data = c_word; in_sel = 2'd3;
        #1;
        check("ind_ready", {191'b0, in_ready}, {191'b0, 1'b1});
        tick();
        in_valid = 1'b0;
        check("ind_valid", {188'b0, out_valid}, {188'b0, 4'b1001});
        check("ind_ch3", {144'b0, out_data[3*W +: W]}, {144'b0, c_word});
        check("ind_ch0", {144'b0, out_data[0*W +: W]}, {144'b0, d_word});
        tick();
        out_ready = 4'b1111;
        tick();

        // Randomized stream honouring the hold-until-accepted rule.
        sent = 0; budget = 0; in_valid = 1'b0;
        while (sent < 20 && budget < 500) begin
            if (!in_valid) begin
                in_valid = 1'($urandom_range(0, 3) != 0);
                in_data  = {$urandom, $urandom};
                in_sel   = 2'($urandom);
            end
            out_ready = 4'($urandom);
            #1;
            if (in_valid && model_ready()) begin
                sent++;
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
            budget++;
        end
        if (sent < 20) check("stream_budget", 192'(sent), 192'd20);
        in_valid = 1'b0; out_ready = '1;
        tick();
        tick();
        for (int i = 0; i < CH; i++) check("sb_leftover", 192'(sb_q[i].size()), '0);

        // Reset mid-flight with all channels full and stalled.
        out_ready = '0; in_valid = 1'b1;
        for (int i = 0; i < CH; i++) begin
            in_sel = 2'(i); in_data = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        check("full_valid", {188'b0, out_valid}, {188'b0, 4'b1111});
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_valid", {188'b0, out_valid}, '0);
        check("mid_rst_ready", {191'b0, in_ready}, {191'b0, 1'b1});
`ifdef DEMUX_XFER_CNT_EN
        check("mid_rst_cnt", {128'b0, xfer_cnt}, '0);
`endif
        out_ready = '1;
        in_data = 48'h0123_4567_89AB; in_sel = 2'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("after_rst_valid", {188'b0, out_valid}, {188'b0, 4'b0010});
        check("after_rst_data", {144'b0, out_data[1*W +: W]}, {144'b0, 48'h0123_4567_89AB});
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
